uart_tx_phy_fsm: RTL
====================

UART_TX_PHY_FSM -- requirements
Module: uart_tx_phy_fsm

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the payload bits per frame.
REQ-002 Parameter OVERSAMPLE_RATE, default 16, SHALL set the number of baud_rate_oversample ticks per bit period.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset, sampled on the sys_clk rising edge.
REQ-005 baud_rate_oversample  input  1  SHALL be a one-sys_clk-wide enable pulse at 57600*16 Hz (the tick).
REQ-006 tx_valid  input  1  SHALL mean that tx_data holds a byte offered for transmission.
REQ-007 tx_data  input  DATA_WIDTH  SHALL carry the payload byte, sampled on acceptance.
REQ-008 tx_ready  output  1  SHALL be high when the holding register is empty.
REQ-009 tx_line  output  1  SHALL be the registered serial line; idle level is 1.
REQ-010 tx_busy  output  1  SHALL be high whenever the FSM is outside IDLE.
REQ-011 tx_done  output  1  SHALL pulse high for exactly one sys_clk cycle at the end of each stop bit.

Function
REQ-012 A byte SHALL be accepted into the holding register on any sys_clk edge where tx_valid && tx_ready, whether or not a tick is present; tx_ready SHALL fall on the next cycle.
REQ-013 tx_valid while tx_ready=0 SHALL be ignored; tx_data SHALL NOT be sampled.
REQ-014 FSM states: IDLE, START, DATA, STOP. All state, bit-counter and tick-counter updates SHALL occur only on cycles with baud_rate_oversample=1.
REQ-015 IDLE->START on a tick with the holding register full: the held byte SHALL move to the shift register, the holding register SHALL empty (tx_ready=1 on the next cycle), and tx_line SHALL go to 0.
REQ-016 Each bit SHALL last exactly OVERSAMPLE_RATE ticks, counted by a tick counter 0..OVERSAMPLE_RATE-1 that wraps to 0 on each bit boundary.
REQ-017 START->DATA after 16 ticks; DATA SHALL drive the bits LSB first, DATA_WIDTH bits of 16 ticks each; DATA->STOP after the last bit.
REQ-018 STOP SHALL drive tx_line=1 for 16 ticks; tx_done SHALL assert on the sys_clk cycle of the final STOP tick.
REQ-019 At the end of STOP, if the holding register is full, the FSM SHALL go directly to START and load the held byte (back-to-back, no idle gap); otherwise it SHALL go to IDLE.
REQ-020 Frame length SHALL be (DATA_WIDTH+2)*OVERSAMPLE_RATE ticks = 160 ticks at defaults.
REQ-021 On a simultaneous acceptance and shift-register load, the new byte SHALL NOT be lost, and it SHALL NOT overwrite the byte being loaded. With tx_ready=0 while full, this conflict cannot occur.
REQ-022 With no ticks present, tx_line and the FSM state SHALL hold their values indefinitely.

Reset
REQ-023 While rst_n=0 at a sys_clk edge, the following SHALL apply on the next cycle: state=IDLE, tick counter=0, bit counter=0, holding register empty, tx_ready=1, tx_line=1, tx_busy=0, tx_done=0.
REQ-024 A reset mid-frame SHALL abort the frame, return tx_line to 1 on the next cycle, and discard the held byte; no tx_done SHALL be issued.

Verification
REQ-025 Send 0x55 once: tx_line = 0, 1,0,1,0,1,0,1,0, then 1; each level lasts 16 ticks; one tx_done pulse at tick 160; tx_busy is high for 160 ticks.
REQ-026 Offer 0xA3, then 0x0F while the first frame is in DATA: tx_ready returns 1 after the 0xA3 load; the STOP of 0xA3 is followed immediately by the START of 0x0F; tx_busy never drops; two tx_done pulses occur 160 ticks apart.
REQ-027 Hold the holding register full and assert tx_valid with 0xFF while tx_ready=0: 0xFF is never transmitted, and the held byte is sent unchanged.
REQ-028 Assert rst_n=0 at DATA bit 3 of 0xC4: next cycle tx_line=1, tx_ready=1, tx_busy=0; no tx_done; a subsequent 0x81 is sent correctly.
REQ-029 Accept 0x3C, then stop the ticks for 1000 sys_clk cycles: tx_line, state and counters are frozen; the frame completes correctly once ticks resume.
REQ-030 Loopback: feed tx_line into the team RX PHY with random bytes (≥256): every rx byte equals the sent byte, and rx_done count equals tx_done count.

Source files
------------

// File: rtl/uart_tx_phy_fsm.sv
// UART transmit PHY: one-byte holding register feeding a START/DATA/STOP serializer
// paced by an oversampling tick; back-to-back frames go out with no idle gap.
module uart_tx_phy_fsm #(
    parameter int DATA_WIDTH      = 8,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  baud_rate_oversample,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_line,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int TICK_W = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  accept;
    logic                  bit_end;
    logic                  load;

    // tx_ready doubles as the holding-register-empty flag, so accept and load are exclusive
    assign accept     = tx_valid && tx_ready;
    assign bit_end    = baud_rate_oversample && (tick_cnt == TICK_LAST);
    assign shift_next = shift_reg >> 1;

    always_comb begin
        load = 1'b0;
        if (baud_rate_oversample && !tx_ready)
            load = (state == IDLE) || (state == STOP && tick_cnt == TICK_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b1;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept)
                tx_ready <= 1'b0;
            else if (load)
                tx_ready <= 1'b1;

            if (baud_rate_oversample) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (load) begin
                            state   <= START;
                            tx_busy <= 1'b1;
                            tx_line <= 1'b0;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            tx_line <= shift_reg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_cnt == BIT_LAST) begin
                                state   <= STOP;
                                tx_line <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_line <= shift_next[0];
                            end
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            tx_done <= 1'b1;
                            if (load) begin
                                state   <= START;
                                tx_line <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Payload registers carry no reset; their contents only matter once flagged valid
    always_ff @(posedge sys_clk) begin
        if (accept)
            hold_reg <= tx_data;
        if (load)
            shift_reg <= hold_reg;
        else if (bit_end && state == DATA)
            shift_reg <= shift_next;
    end

endmodule
